// File: rtl/fetch_stage.sv
// Instruction fetch stage: sequential PC advance, I-cache handshake, stall hold
// buffer and redirect handling with a drain state for an in-flight cache read.
module fetch_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        icache_resp,
  input  logic [15:0] icache_rdata,
  output logic        icache_read,
  output logic [15:0] icache_address,
  output logic [15:0] pc,
  output logic [31:0] ifid_out,
  output logic        ifid_load,
  output logic        ifid_squash
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] hold_buf;
  logic [15:0] pending;
  logic [15:0] pc_plus2;

  assign pc_plus2       = pc + 16'd2;
  assign icache_address = pc;

  // Outputs stay combinational from state so that reset drops the cache
  // request and a redirect squashes IF/ID within the same cycle.
  always_comb begin
    icache_read = 1'b0;
    ifid_load   = 1'b0;
    ifid_squash = redirect | reset;
    ifid_out    = {pc_plus2, icache_rdata};
    if (!reset) begin
      unique case (state)
        FETCH: begin
          icache_read = 1'b1;
          ifid_load   = icache_resp & ~redirect & ~stall;
        end
        HOLD: begin
          ifid_out  = {pc_plus2, hold_buf};
          ifid_load = ~redirect & ~stall;
        end
        DRAIN: icache_read = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      pc       <= '0;
      hold_buf <= '0;
      pending  <= '0;
    end else begin
      unique case (state)
        FETCH: begin
          if (redirect) begin
            if (icache_resp) begin
              pc <= redirect_pc;
            end else begin
              pending <= redirect_pc;
              state   <= DRAIN;
            end
          end else if (icache_resp) begin
            if (stall) begin
              hold_buf <= icache_rdata;
              state    <= HOLD;
            end else begin
              pc <= pc_plus2;
            end
          end
        end
        HOLD: begin
          if (redirect) begin
            pc    <= redirect_pc;
            state <= FETCH;
          end else if (!stall) begin
            pc    <= pc_plus2;
            state <= FETCH;
          end
        end
        DRAIN: begin
          if (redirect) pending <= redirect_pc;
          // The outstanding read completes at the old address; its data is dropped.
          if (icache_resp) begin
            pc    <= redirect ? redirect_pc : pending;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected IF/ID words are queued by the
// stimulus and popped by a monitor whenever the DUT asserts ifid_load.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        icache_resp;
  logic [15:0] icache_rdata;
  logic        icache_read;
  logic [15:0] icache_address;
  logic [15:0] pc;
  logic [31:0] ifid_out;
  logic        ifid_load;
  logic        ifid_squash;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] exp_q[$];

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .icache_resp   (icache_resp),
    .icache_rdata  (icache_rdata),
    .icache_read   (icache_read),
    .icache_address(icache_address),
    .pc            (pc),
    .ifid_out      (ifid_out),
    .ifid_load     (ifid_load),
    .ifid_squash   (ifid_squash)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every load presented by the DUT must match the oldest queued word.
  always @(negedge clk) begin
    if (!reset && ifid_load === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_load", ifid_out, 32'hxxxx_xxxx);
      end else begin
        check("ifid_out", ifid_out, exp_q.pop_front());
      end
    end
  end

  task automatic drive(input logic st, input logic rd, input logic [15:0] rpc,
                       input logic rsp, input logic [15:0] rdat);
    stall        = st;
    redirect     = rd;
    redirect_pc  = rpc;
    icache_resp  = rsp;
    icache_rdata = rdat;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // Check the per-cycle handshake outputs at the negedge.
  task automatic expect_io(input string tag, input logic rd, input logic [15:0] addr,
                           input logic ld, input logic sq);
    check({tag, "_read"}, {31'd0, icache_read}, {31'd0, rd});
    if (rd) check({tag, "_addr"}, {16'd0, icache_address}, {16'd0, addr});
    check({tag, "_load"}, {31'd0, ifid_load}, {31'd0, ld});
    check({tag, "_squash"}, {31'd0, ifid_squash}, {31'd0, sq});
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h5555);
    settle();
    expect_io("rst", 1'b0, 16'h0000, 1'b0, 1'b1);
    check("rst_pc", {16'd0, pc}, 32'h0);
    advance();
    advance();
    check("rst_pc_after_resp", {16'd0, pc}, 32'h0);

    // Back-to-back responses from 0x0000 up to 0x000E.
    reset = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'hA000 + 16'(i));
      exp_q.push_back({16'(2 * i + 2), 16'hA000 + 16'(i)});
      settle();
      expect_io("seq", 1'b1, 16'(2 * i), 1'b1, 1'b0);
      advance();
    end

    // Stall at 0x0010 for three cycles, then release from HOLD.
    drive(1'b1, 1'b0, 16'h0000, 1'b1, 16'h1234);
    settle();
    expect_io("stall_cap", 1'b1, 16'h0010, 1'b0, 1'b0);
    advance();
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
    for (int unsigned i = 0; i < 2; i++) begin
      settle();
      expect_io("hold", 1'b0, 16'h0000, 1'b0, 1'b0);
      advance();
    end
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    exp_q.push_back(32'h0012_1234);
    settle();
    expect_io("hold_rel", 1'b0, 16'h0000, 1'b1, 1'b0);
    advance();
    settle();
    expect_io("after_hold", 1'b1, 16'h0012, 1'b0, 1'b0);
    advance();

    // Redirect with a response and stall: data discarded, next address 0x0008.
    drive(1'b1, 1'b1, 16'h0008, 1'b1, 16'hDEAD);
    settle();
    expect_io("redir_resp", 1'b1, 16'h0012, 1'b0, 1'b1);
    advance();

    // Redirect to 0x0040 with no response: drain at 0x0008.
    drive(1'b0, 1'b1, 16'h0040, 1'b0, 16'h0000);
    settle();
    expect_io("redir_nresp", 1'b1, 16'h0008, 1'b0, 1'b1);
    advance();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    settle();
    expect_io("drain_wait", 1'b1, 16'h0008, 1'b0, 1'b0);
    advance();
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'hBAD0);
    settle();
    expect_io("drain_resp", 1'b1, 16'h0008, 1'b0, 1'b0);
    advance();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    settle();
    expect_io("drain_done", 1'b1, 16'h0040, 1'b0, 1'b0);
    advance();

    // Two redirects while draining: the latest target wins.
    drive(1'b0, 1'b1, 16'h0060, 1'b0, 16'h0000);
    advance();
    drive(1'b0, 1'b1, 16'h0080, 1'b0, 16'h0000);
    settle();
    expect_io("drain_redir", 1'b1, 16'h0040, 1'b0, 1'b1);
    advance();
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'hBAD1);
    advance();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    settle();
    expect_io("latest_wins", 1'b1, 16'h0080, 1'b0, 1'b0);
    advance();

    // Redirect coinciding with the drain response takes the new target.
    drive(1'b0, 1'b1, 16'h0200, 1'b0, 16'h0000);
    advance();
    drive(1'b0, 1'b1, 16'h0300, 1'b1, 16'hBAD2);
    settle();
    expect_io("drain_redir_resp", 1'b1, 16'h0080, 1'b0, 1'b1);
    advance();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    settle();
    expect_io("drain_redir_tgt", 1'b1, 16'h0300, 1'b0, 1'b0);
    advance();

    // Redirect out of HOLD beats the stall.
    drive(1'b1, 1'b0, 16'h0000, 1'b1, 16'h7777);
    advance();
    drive(1'b1, 1'b1, 16'h0400, 1'b0, 16'h0000);
    settle();
    expect_io("hold_redir", 1'b0, 16'h0000, 1'b0, 1'b1);
    advance();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    settle();
    expect_io("hold_redir_tgt", 1'b1, 16'h0400, 1'b0, 1'b0);
    advance();

    // PC wrap at 0xFFFE.
    drive(1'b0, 1'b1, 16'hFFFE, 1'b1, 16'h0000);
    advance();
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'hBEEF);
    exp_q.push_back(32'h0000_BEEF);
    settle();
    expect_io("wrap", 1'b1, 16'hFFFE, 1'b1, 1'b0);
    advance();
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001);
    exp_q.push_back(32'h0002_0001);
    settle();
    expect_io("wrap_next", 1'b1, 16'h0000, 1'b1, 1'b0);
    advance();

    // Reset mid-request: read drops at once and a late response is ignored.
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_read", {31'd0, icache_read}, 32'h0);
    check("midrst_pc", {16'd0, pc}, 32'h0);
    icache_resp = 1'b1;
    advance();
    check("midrst_late_resp_pc", {16'd0, pc}, 32'h0);
    reset = 1'b0;
    icache_resp = 1'b0;
    settle();
    expect_io("post_rst", 1'b1, 16'h0000, 1'b0, 1'b0);
    advance();

    advance();
    check("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous, active-high reset, reset; ports are listed below as name, direction, width, meaning.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  async active-high; clears PC, state and hold buffer.
REQ-004 stall  in  1  downstream cannot accept an instruction this cycle.
REQ-005 redirect  in  1  branch/jmp/jsr/trap taken; overrides sequential fetch.
REQ-006 redirect_pc  in  16  target address, valid while redirect=1.
REQ-007 icache_resp  in  1  instruction cache read complete this cycle.
REQ-008 icache_rdata  in  16  instruction word, valid when icache_resp=1.
REQ-009 icache_read  out  1  instruction cache read request.
REQ-010 icache_address  out  16  read address; held stable while a request is outstanding.
REQ-011 pc  out  16  current fetch PC.
REQ-012 ifid_out  out  32  {pc+2, instruction} for the IF/ID register (bits 31:16 next PC, bits 15:0 instruction).
REQ-013 ifid_load  out  1  IF/ID register load enable.
REQ-014 ifid_squash  out  1  IF/ID register clear; drives its reset input.

Function
REQ-015 States SHALL be FETCH, HOLD and DRAIN, plus a 16-bit PC, a 16-bit hold buffer and a 16-bit pending-target register.
REQ-016 pc+2 SHALL wrap modulo 2^16 (0xFFFE -> 0x0000).
REQ-017 FETCH: icache_read=1, icache_address=pc.
REQ-018 FETCH, icache_resp=1, redirect=0, stall=0: ifid_load=1, ifid_out={pc+2, icache_rdata}, pc<=pc+2 at the edge, stay FETCH (one instruction per cycle on back-to-back responses).
REQ-019 FETCH, icache_resp=1, redirect=0, stall=1: ifid_load=0, hold buffer<=icache_rdata, go to HOLD; pc unchanged.
REQ-020 FETCH, icache_resp=1, redirect=1: discard the response, pc<=redirect_pc, stay FETCH.
REQ-021 FETCH, icache_resp=0, redirect=1: pending<=redirect_pc, go to DRAIN; icache_address stays pc.
REQ-022 HOLD: icache_read=0; ifid_out={pc+2, hold buffer}. If redirect=1, pc<=redirect_pc and go to FETCH; else if stall=0, ifid_load=1, pc<=pc+2 and go to FETCH; else stay HOLD.
REQ-023 DRAIN: icache_read=1, icache_address=pc (old address), ifid_load=0. If redirect=1, pending<=redirect_pc (latest wins). On icache_resp=1, discard the data, pc<=pending (or redirect_pc if redirect=1 that cycle) and go to FETCH.
REQ-024 ifid_squash SHALL equal redirect combinationally in every state; ifid_load SHALL be 0 whenever redirect=1.
REQ-025 Priority SHALL be: reset > redirect > stall > sequential advance.
REQ-026 ifid_load SHALL never be 1 with ifid_squash=1, and never be 1 in DRAIN.
REQ-027 In FETCH with icache_resp=0, ifid_out={pc+2, icache_rdata}; ifid_out is only guaranteed meaningful when ifid_load=1.

Reset
REQ-028 While reset=1: state=FETCH, pc=0x0000, hold buffer=0, pending=0, icache_read=0, ifid_load=0, ifid_squash=1.
REQ-029 The first cycle after reset deasserts SHALL present icache_read=1 and icache_address=0x0000.
REQ-030 Reset asserted mid-request (FETCH or DRAIN) SHALL drop icache_read immediately; a late icache_resp SHALL NOT change pc or state.

Verification
REQ-031 Reset release, resp=1 every cycle, stall=0 -> ifid_out upper half = 0x0002, 0x0004, 0x0006 on consecutive cycles, ifid_load=1 each cycle.
REQ-032 Resp with rdata=0x1234 at pc=0x0010 while stall=1 for 3 cycles -> HOLD, icache_read=0, ifid_load=0; on stall=0 -> ifid_load=1, ifid_out=0x00121234, then fetch from 0x0012.
REQ-033 Redirect to 0x0040 at pc=0x0008 with no resp -> ifid_squash=1, DRAIN, address stays 0x0008 until resp; next cycle address=0x0040.
REQ-034 Redirect to 0x0040 then 0x0080 during DRAIN -> after resp, fetch address=0x0080.
REQ-035 Redirect to 0x0100 coinciding with resp and stall=1 -> data discarded, ifid_load=0, ifid_squash=1, next address=0x0100.
REQ-036 pc=0xFFFE, resp=1, stall=0 -> ifid_out[31:16]=0x0000, next address=0x0000.
